fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Shares the single write port of the dual-clock FIFO (dcfifo) among NREQ requesters in the write-clock domain.
- Round-robin grant with bounded bursts: a granted requester keeps the port for up to MAX_BURST beats or until it drops valid.
- Respects FIFO full by back-pressuring requesters.
- Sits directly in front of dcfifo wr/din/full.

Parameters:
- NREQ, 4, number of requesters (2..8)
- WIDTH, 8, data width; matches dcfifo WIDTH
- MAX_BURST, 4, maximum beats per grant (1..16)

Ports:
- clock  input  1  write-domain clock (drives dcfifo w_clock)
- resetn  input  1  synchronous active-low reset
- req_valid  input  NREQ  per-requester data valid
- req_data  input  NREQ*WIDTH  requester i data at bits [i*WIDTH +: WIDTH]
- req_ready  output  NREQ  per-requester accept; a beat transfers when req_valid[i] & req_ready[i]
- full  input  1  dcfifo full
- wr  output  1  dcfifo write strobe
- din  output  WIDTH  dcfifo write data
- grant_id  output  $clog2(NREQ)  index of current grantee; valid while busy=1
- busy  output  1  arbiter in GRANT state

Behaviour:
- Reset:
  - Synchronous: sampled at the posedge of clock while resetn=0.
  - Clears state to IDLE, pointer to 0, grant_id to 0, burst count to 0.
  - Takes effect on that edge even mid-burst. No beat is written in that cycle.
- Outputs during reset and in IDLE: wr=0, din=0, req_ready=0, busy=0.
- Registered state: state (IDLE/GRANT), grant_id, burst count cnt (0..MAX_BURST-1), round-robin pointer ptr.
- IDLE:
  - If any req_valid is set, select the first set index searching ptr, ptr+1, ... modulo NREQ.
  - Next edge: state=GRANT, grant_id=selected index, cnt=0.
  - Arbitration latency is 1 cycle from valid to grant.
  - If no req_valid is set, stay in IDLE.
- GRANT, with g = grant_id. All outputs below are combinational from the registered state and the current inputs:
  - req_ready[g] = ~full; all other req_ready bits are 0.
  - wr = req_valid[g] & ~full.
  - din = req_data[g] when wr=1, else 0.
  - busy = 1.
- GRANT transitions, evaluated at each edge:
  - Transfer (wr=1) with cnt==MAX_BURST-1: go to IDLE, ptr=(g+1) mod NREQ, cnt=0.
  - Transfer with cnt<MAX_BURST-1: cnt=cnt+1, stay in GRANT.
  - req_valid[g]=0: release. Go to IDLE, ptr=(g+1) mod NREQ, cnt unchanged (cleared on the next grant).
  - full=1 and req_valid[g]=1: stall. Hold state, grant_id and cnt. No timeout.
- Fairness:
  - Each grant is followed by at least one IDLE cycle (bubble).
  - A requester holding valid high waits at most (NREQ-1) grants.
- Simultaneous events:
  - full rising in the same cycle as a would-be transfer blocks the write. No beat is counted or lost.
  - Valid changes on non-granted requesters have no effect until IDLE.
- MAX_BURST=1: every transfer returns to IDLE. Port throughput is 50% of cycles at most.
- No data is buffered internally; ordering within one requester is preserved.
- grant_id wraps modulo NREQ; ptr arithmetic uses $clog2(NREQ) bits with explicit wrap for non-power-of-2 NREQ.

Test Plan:
- Reset behaviour: hold resetn=0 for 10 cycles with all req_valid=1 -> wr=0, req_ready=0, busy=0 throughout. First grant after release is grant_id=0 one cycle after resetn=1.
- Single requester: req 2 streams 0x10..0x19 (10 beats), full=0 -> beats written in order. Grants split into bursts 4,4,2 with one IDLE bubble between each. All grant_id=2.
- Round-robin: all 4 requesters valid continuously with distinct data -> grant order 0,1,2,3,0,..., 4 beats each. The FIFO sequence interleaves in 4-beat blocks.
- Back-pressure: full=1 for 5 cycles mid-burst after beat 2 of requester 1 -> wr=0 and req_ready[1]=0 for those 5 cycles, cnt held. Beats 3 and 4 follow after full drops; no duplicates, no loss.
- Early release: requester 3 drops valid after 2 beats while requester 0 is valid -> IDLE, then grant_id=0 (ptr wrapped from 3 to 0).
- Reset mid-burst: resetn=0 for 1 cycle during requester 1's beat 2 -> no write on the reset edge, state IDLE, ptr=0. Next grant goes to the lowest-index valid requester.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: shares the dcfifo write port among NREQ write-domain requesters.
// A round-robin pointer picks the next grantee from IDLE. The grantee then owns the
// port until it has moved MAX_BURST beats or drops valid. No data is buffered here:
// din is muxed straight from the grantee, and full back-pressures it through req_ready.
// The grantee always returns to IDLE for at least one cycle before the next grant.
module fifo_wr_arbiter #(
    parameter int NREQ      = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*WIDTH-1:0]     req_data,
    output logic [NREQ-1:0]           req_ready,
    input  logic                      full,
    output logic                      wr,
    output logic [WIDTH-1:0]          din,
    output logic [$clog2(NREQ)-1:0]   grant_id,
    output logic                      busy
);

    localparam int IDW = $clog2(NREQ);
    localparam int CW  = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    localparam logic [IDW-1:0] LAST_ID   = IDW'(NREQ - 1);
    localparam logic [CW-1:0]  LAST_BEAT = CW'(MAX_BURST - 1);

    logic [0:0]       state;
    logic [IDW-1:0]   ptr;
    logic [CW-1:0]    cnt;

    logic             any_valid;
    logic [IDW-1:0]   pick;
    logic [IDW-1:0]   next_ptr;
    logic             granted_valid;
    logic [WIDTH-1:0] granted_data;
    logic             active;
    int               idx;
    logic [IDW-1:0]   idx_n;

    // Round-robin search: first valid requester at or after ptr, with wrap for any NREQ.
    always_comb begin
        any_valid = 1'b0;
        pick      = '0;
        idx       = 0;
        idx_n     = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            idx_n = IDW'(idx);
            if (!any_valid && req_valid[idx_n]) begin
                any_valid = 1'b1;
                pick      = idx_n;
            end
        end
    end

    // Select the current grantee's valid and data lanes.
    always_comb begin
        granted_valid = 1'b0;
        granted_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_id == IDW'(i)) begin
                granted_valid = req_valid[i];
                granted_data  = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign next_ptr = (grant_id == LAST_ID) ? '0 : grant_id + IDW'(1);

    // Gated by resetn, so the reset edge can never also count as a write.
    assign active = resetn && (state == GRANT);

    // Port outputs: only the grantee sees ready, and din is forced to zero between beats.
    always_comb begin
        req_ready = '0;
        wr        = 1'b0;
        din       = '0;
        busy      = active;
        if (active) begin
            req_ready[grant_id] = ~full;
            wr                  = granted_valid & ~full;
            if (granted_valid && !full) begin
                din = granted_data;
            end
        end
    end

    // Grant state machine: IDLE picks a winner, GRANT counts beats, stalls on full, releases.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state    <= IDLE;
            ptr      <= '0;
            grant_id <= '0;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        state    <= GRANT;
                        grant_id <= pick;
                        cnt      <= '0;
                    end
                end
                GRANT: begin
                    if (!granted_valid) begin
                        state <= IDLE;
                        ptr   <= next_ptr;
                    end else if (!full) begin
                        if (cnt == LAST_BEAT) begin
                            state <= IDLE;
                            ptr   <= next_ptr;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed bench for fifo_wr_arbiter with a beat-level reference model.
// Each requester is a queue of pending beats, and valid means its queue is non-empty.
// The model tracks who owns the port and how many beats it has moved.
// A negedge process checks every DUT output against the model on every cycle.
// Per-scenario logs of written beats and grants are also checked against literal tables.
module tb_fifo_wr_arbiter;

    localparam int NREQ      = 4;
    localparam int WIDTH     = 8;
    localparam int MAX_BURST = 4;
    localparam int IDW       = 2;

    logic                  clock = 1'b0;
    logic                  resetn;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  full;
    logic                  wr;
    logic [WIDTH-1:0]      din;
    logic [IDW-1:0]        grant_id;
    logic                  busy;

    int total = 0;
    int bad   = 0;
    bit checking = 1'b0;

    int src_q [NREQ][$];

    // Reference model state: owner of the port, beats moved in this grant, next priority.
    bit m_busy  = 1'b0;
    int m_owner = 0;
    int m_beats = 0;
    int m_next  = 0;

    // Observations of the DUT for literal per-scenario checks.
    int dut_data[$];
    int dut_ids[$];
    int dut_grants[$];
    int dut_bursts[$];
    bit prev_busy = 1'b0;

    int exp_data[$];
    int exp_ids[$];
    int exp_grants[$];
    int exp_bursts[$];

    fifo_wr_arbiter #(
        .NREQ      (NREQ),
        .WIDTH     (WIDTH),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .full      (full),
        .wr        (wr),
        .din       (din),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < NREQ; i++) begin
            logic [31:0] v;
            if (src_q[i].size() > 0) begin
                v = src_q[i][0];
                req_valid[i] = 1'b1;
                req_data[i*WIDTH +: WIDTH] = v[WIDTH-1:0];
            end else begin
                req_valid[i] = 1'b0;
                req_data[i*WIDTH +: WIDTH] = '0;
            end
        end
    endtask

    function automatic int first_valid_from(input int start);
        for (int k = 0; k < NREQ; k++) begin
            if (req_valid[(start + k) % NREQ]) return (start + k) % NREQ;
        end
        return -1;
    endfunction

    // Advance the model by one clock edge using the inputs that were present at that edge.
    task automatic model_step();
        int j;
        if (!resetn) begin
            m_busy = 1'b0; m_owner = 0; m_beats = 0; m_next = 0;
        end else if (!m_busy) begin
            j = first_valid_from(m_next);
            if (j >= 0) begin
                m_busy = 1'b1; m_owner = j; m_beats = 0;
            end
        end else if (!req_valid[m_owner]) begin
            m_busy = 1'b0;
            m_next = (m_owner + 1) % NREQ;
        end else if (!full) begin
            void'(src_q[m_owner].pop_front());
            m_beats++;
            if (m_beats == MAX_BURST) begin
                m_busy = 1'b0;
                m_next = (m_owner + 1) % NREQ;
            end
        end
    endtask

    task automatic tick(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clock);
            model_step();
            #1;
            drive_inputs();
        end
    endtask

    task automatic clear_logs();
        dut_data.delete(); dut_ids.delete(); dut_grants.delete(); dut_bursts.delete();
        exp_data.delete(); exp_ids.delete(); exp_grants.delete(); exp_bursts.delete();
    endtask

    task automatic do_reset();
        for (int i = 0; i < NREQ; i++) src_q[i].delete();
        resetn = 1'b0;
        full   = 1'b0;
        drive_inputs();
        tick(2);
        resetn = 1'b1;
        drive_inputs();
        clear_logs();
    endtask

    task automatic check_output(input string tag);
        check_val({tag, " beat_count"}, dut_data.size(), exp_data.size());
        for (int i = 0; i < exp_data.size() && i < dut_data.size(); i++) begin
            check_val($sformatf("%s data[%0d]", tag, i), dut_data[i], exp_data[i]);
            check_val($sformatf("%s beat_id[%0d]", tag, i), dut_ids[i], exp_ids[i]);
        end
        check_val({tag, " grant_count"}, dut_grants.size(), exp_grants.size());
        for (int i = 0; i < exp_grants.size() && i < dut_grants.size(); i++) begin
            check_val($sformatf("%s grant[%0d]", tag, i), dut_grants[i], exp_grants[i]);
            check_val($sformatf("%s burst[%0d]", tag, i), dut_bursts[i], exp_bursts[i]);
        end
    endtask

    // Compare every DUT output with the model each cycle, and log observed beats and grants.
    always @(negedge clock) begin
        logic             exp_busy;
        logic             exp_wr;
        logic [NREQ-1:0]  exp_ready;
        logic [31:0]      exp_din;
        if (checking) begin
            exp_busy  = resetn && m_busy;
            exp_wr    = 1'b0;
            exp_ready = '0;
            exp_din   = '0;
            if (exp_busy) begin
                exp_ready[m_owner] = !full;
                exp_wr = req_valid[m_owner] && !full;
                if (exp_wr) exp_din = src_q[m_owner][0];
            end
            check_val("busy", {31'd0, busy}, {31'd0, exp_busy});
            check_val("wr", {31'd0, wr}, {31'd0, exp_wr});
            check_val("din", {24'd0, din}, exp_din);
            check_val("req_ready", {28'd0, req_ready}, {28'd0, exp_ready});
            if (exp_busy) check_val("grant_id", {30'd0, grant_id}, m_owner);

            if (busy && !prev_busy) begin
                dut_grants.push_back(int'(grant_id));
                dut_bursts.push_back(0);
            end
            if (wr) begin
                dut_data.push_back(int'(din));
                dut_ids.push_back(int'(grant_id));
                if (dut_bursts.size() > 0) dut_bursts[dut_bursts.size()-1]++;
            end
            prev_busy = busy;
        end
    end

    task automatic apply_stimulus();
        // Reset held with every requester valid: nothing granted or written.
        resetn = 1'b0; full = 1'b0; req_valid = '0; req_data = '0;
        for (int i = 0; i < NREQ; i++)
            for (int k = 0; k < 6; k++) src_q[i].push_back(8'h40 + 16 * i + k);
        drive_inputs();
        tick(1);
        checking = 1'b1;
        tick(9);
        check_val("reset no_writes", dut_data.size(), 0);
        check_val("reset no_grants", dut_grants.size(), 0);
        resetn = 1'b1;
        drive_inputs();
        tick(1);
        #1;
        check_val("first_grant busy", {31'd0, busy}, 1);
        check_val("first_grant id", {30'd0, grant_id}, 0);

        // One requester streaming ten beats splits into bursts of 4, 4, 2.
        do_reset();
        for (int k = 0; k < 10; k++) src_q[2].push_back(8'h10 + k);
        drive_inputs();
        tick(30);
        for (int k = 0; k < 10; k++) begin exp_data.push_back(8'h10 + k); exp_ids.push_back(2); end
        exp_grants = '{2, 2, 2};
        exp_bursts = '{4, 4, 2};
        check_output("single");

        // All four requesters busy: 4-beat blocks in order 0,1,2,3,0,1,2,3.
        do_reset();
        for (int i = 0; i < NREQ; i++)
            for (int k = 0; k < 8; k++) src_q[i].push_back(16 * i + k);
        drive_inputs();
        tick(50);
        for (int b = 0; b < 2; b++)
            for (int r = 0; r < NREQ; r++) begin
                exp_grants.push_back(r);
                exp_bursts.push_back(4);
                for (int k = 0; k < 4; k++) begin
                    exp_data.push_back(16 * r + 4 * b + k);
                    exp_ids.push_back(r);
                end
            end
        check_output("round_robin");

        // Full for 5 cycles after beat 2 of requester 1.
        do_reset();
        for (int k = 0; k < 4; k++) src_q[1].push_back(8'hA0 + k);
        drive_inputs();
        tick(3);
        check_val("bp beats_before_full", dut_data.size(), 2);
        full = 1'b1;
        drive_inputs();
        for (int c = 0; c < 5; c++) begin
            #1;
            check_val("bp wr_low", {31'd0, wr}, 0);
            check_val("bp ready_low", {28'd0, req_ready}, 0);
            check_val("bp busy_held", {31'd0, busy}, 1);
            tick(1);
        end
        check_val("bp beats_during_full", dut_data.size(), 2);
        full = 1'b0;
        drive_inputs();
        tick(8);
        exp_data = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        exp_ids = '{1, 1, 1, 1};
        exp_grants = '{1};
        exp_bursts = '{4};
        check_output("backpressure");

        // Pointer parked at 3 by an early release of 2; requester 3 releases early and ptr wraps to 0.
        do_reset();
        src_q[2].push_back(8'h2F);
        drive_inputs();
        tick(1);
        src_q[3].push_back(8'h31); src_q[3].push_back(8'h32);
        src_q[0].push_back(8'h01); src_q[0].push_back(8'h02);
        drive_inputs();
        tick(15);
        exp_data = '{8'h2F, 8'h31, 8'h32, 8'h01, 8'h02};
        exp_ids = '{2, 3, 3, 0, 0};
        exp_grants = '{2, 3, 0};
        exp_bursts = '{1, 2, 2};
        check_output("early_release");

        // One-cycle reset during requester 1's second beat.
        do_reset();
        for (int k = 0; k < 4; k++) src_q[1].push_back(8'hB0 + k);
        src_q[2].push_back(8'hC0); src_q[2].push_back(8'hC1);
        drive_inputs();
        tick(2);
        resetn = 1'b0;
        drive_inputs();
        #1;
        check_val("midreset wr", {31'd0, wr}, 0);
        check_val("midreset busy", {31'd0, busy}, 0);
        check_val("midreset ready", {28'd0, req_ready}, 0);
        tick(1);
        resetn = 1'b1;
        drive_inputs();
        tick(15);
        exp_data = '{8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hC0, 8'hC1};
        exp_ids = '{1, 1, 1, 1, 2, 2};
        exp_grants = '{1, 1, 2};
        exp_bursts = '{1, 3, 2};
        check_output("mid_reset");
    endtask

    // Drive the scenarios and print the summary.
    initial begin
        apply_stimulus();
        checking = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
